seq_multiplier: RTL and testbench

Iterative shift-and-add multiplier for the datapath's multiply instructions. Takes two N-bit operands, signed or unsigned, and produces a 2N-bit product as separate high and low words. It runs one partial-product addition per cycle through the catalog `adder`, which it instantiates. It sits beside the ALU, and its hi/lo outputs feed the hi/lo register writeback path.

---
 rtl/mult_pkg.sv | 10 +
 rtl/adder.sv | 12 +
 rtl/seq_multiplier.sv | 108 ++++++++++
 tb/tb_seq_multiplier.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder.sv
// Catalog ripple adder: plain W-bit sum, carry discarded by the caller's sizing.
module adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier: one partial-product add per cycle,
// sign handled by multiplying magnitudes and negating the 2N-bit result.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = cnt_width(N);

    mult_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N:0]    p_q, p_d;
    logic [N-1:0]    a_mag_q, a_mag_d;
    logic            neg_q, neg_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;

    logic [N:0]      upper_sum;
    logic [N:0]      upper_next;
    logic [N-1:0]    a_mag_in;
    logic [N-1:0]    b_mag_in;
    logic [2*N-1:0]  prod;

    // Upper accumulator is N+1 bits wide so the add carry lands in P[2N].
    adder #(.W(N + 1)) u_adder (
        .a   (p_q[2*N:N]),
        .b   ({1'b0, a_mag_q}),
        .sum (upper_sum)
    );

    always_comb begin
        a_mag_in   = (is_signed && a[N-1]) ? -a : a;
        b_mag_in   = (is_signed && b[N-1]) ? -b : b;
        upper_next = p_q[0] ? upper_sum : p_q[2*N:N];
        prod       = neg_q ? -p_q[2*N-1:0] : p_q[2*N-1:0];

        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_mag_d = a_mag_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    neg_d   = is_signed & (a[N-1] ^ b[N-1]);
                    a_mag_d = a_mag_in;
                    p_d     = {{(N + 1){1'b0}}, b_mag_in};
                    cnt_d   = '0;
                end
            end
            RUN: begin
                p_d   = {1'b0, upper_next, p_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = prod;
                state_d      = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_mag_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_mag_q <= a_mag_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected products,
// a negedge monitor pops and checks them whenever done is presented.
module tb_seq_multiplier;

    localparam int N = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          is_signed;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;

    typedef struct {
        logic [2*N-1:0] prod;
        int             acc;
    } exp_t;

    exp_t           q[$];
    int             checks;
    int             failures;
    int             cyc;
    int             busy_run;
    logic [N-1:0]   last_hi;
    logic [N-1:0]   last_lo;

    seq_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic s);
        logic [2*N-1:0] ex;
        logic [2*N-1:0] ey;
        ex = s ? {{N{x[N-1]}}, x} : {{N{1'b0}}, x};
        ey = s ? {{N{y[N-1]}}, y} : {{N{1'b0}}, y};
        return ex * ey;
    endfunction

    task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mul(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        exp_t e;
        int   t;
        t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        a         = x;
        b         = y;
        is_signed = s;
        start     = 1'b1;
        e.prod    = ref_mul(x, y, s);
        e.acc     = cyc + 1;
        q.push_back(e);
        $display("issue a=%h b=%h signed=%0d expect=%h", x, y, s, e.prod);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 4 * N) begin
            tick();
            t++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout got=0 expected=1");
        end
    endtask

    // Monitor: results, latency, busy length, hi/lo stability while busy.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (busy && done) begin
            failures++;
            $display("FAIL busy_and_done got=11 expected=not both");
        end
        if (done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got=done expected=no pending op");
            end else begin
                e = q.pop_front();
                check("product", {hi, lo}, e.prod);
                check("latency", 64'(cyc), 64'(e.acc + N + 1));
                check("busy_len", 64'(busy_run), 64'(N + 1));
                $display("result hi=%h lo=%h expect=%h", hi, lo, e.prod);
                last_hi = e.prod[2*N-1:N];
                last_lo = e.prod[N-1:0];
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
            check("hold_while_busy", {hi, lo}, {last_hi, last_lo});
        end else begin
            busy_run = 0;
        end
        if (rst) begin
            q.delete();
            last_hi  = '0;
            last_lo  = '0;
            busy_run = 0;
        end
    end

    initial begin
        int first_done;
        int t;
        exp_t e;
        checks    = 0;
        failures  = 0;
        busy_run  = 0;
        last_hi   = '0;
        last_lo   = '0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));
        rst = 1'b0;

        do_mul(32'd6, 32'd7, 1'b0);
        wait_done();
        repeat (100) begin
            tick();
            check("hold_idle_hilo", {hi, lo}, {32'h0, 32'h2A});
            check("hold_idle_done", 64'(done), 64'(0));
        end

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_mul(-32'sd3, 32'd5, 1'b1);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done();

        // A start mid-RUN must be ignored; a start held in DONE is accepted.
        do_mul(32'd123, 32'd456, 1'b0);
        repeat (5) tick();
        a = 32'd999; b = 32'd888; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        first_done = cyc;
        a = 32'hDEAD_BEEF; b = 32'h0000_1234; is_signed = 1'b1; start = 1'b1;
        e.prod = ref_mul(a, b, 1'b1);
        e.acc  = cyc + 1;
        q.push_back(e);
        $display("issue a=%h b=%h signed=1 expect=%h (held in DONE)", a, b, e.prod);
        tick();
        start = 1'b0;
        wait_done();
        check("back_to_back_spacing", 64'(cyc - first_done), 64'(N + 2));

        // Reset at iteration 10 discards the operation.
        do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hilo", {hi, lo}, 64'(0));
        repeat (40) tick();
        do_mul(32'd0, 32'h1234_5678, 1'b0);
        wait_done();

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] x;
            logic [N-1:0] y;
            x = $urandom;
            y = $urandom;
            if (i % 8 == 1) x = 32'h8000_0000;
            if (i % 8 == 2) y = 32'hFFFF_FFFF;
            if (i % 8 == 3) x = 32'd0;
            do_mul(x, y, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end
        t = 0;
        while (q.size() != 0 && t < 8 * N) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check("pending_ops", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
